// File: rtl/bus_lane_arbiter_x2_pkg.sv
// Shared definitions for the two-lane bus arbiter: FSM encoding and lane identifiers.
package bus_lane_arbiter_x2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_id_e;

  // Width of a counter that must reach max_val inclusive, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/bus_lane_arbiter_x2_hold.sv
// Saturating hold counter with synchronous clear and a terminal-count flag
// that marks the last cycle a contended grant may be kept.
module bus_lane_arbiter_x2_hold
  import bus_lane_arbiter_x2_pkg::*;
#(
  parameter int unsigned UUID     = 0,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = cnt_width(HOLD_MAX);
  localparam logic [W-1:0] MAX_C = W'(HOLD_MAX);
  localparam logic [W-1:0] TC_C  = (HOLD_MAX > 0) ? W'(HOLD_MAX - 1) : '0;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until pinned at HOLD_MAX.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (HOLD_MAX != 0) && (count_q == TC_C);

endmodule

// File: rtl/bus_lane_arbiter_x2.sv
// Round-robin arbiter owning two shared 1-bit lanes, with a one-cycle turnaround
// between owners and optional preemption of a grant held against contention.
module bus_lane_arbiter_x2
  import bus_lane_arbiter_x2_pkg::*;
#(
  parameter int unsigned UUID     = 0,
  parameter string       NAME     = "",
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic Req1,
  input  logic Req2,
  input  logic Data1,
  input  logic Data2,
  output logic Grant1,
  output logic Grant2,
  output logic Output1,
  output logic Output2,
  output logic Preempt
);

  arb_state_e state_q, state_d;
  lane_id_e   last_q, last_d;
  logic       preempt_q, preempt_d;
  logic       own_q, own_d;
  logic       hold_tc;

  assign own_q = (state_q == OWN1) || (state_q == OWN2);
  assign own_d = (state_d == OWN1) || (state_d == OWN2);

  // Counter runs only while a grant persists across an edge; it reads zero
  // in every non-owning cycle so each new grant starts counting from zero.
  bus_lane_arbiter_x2_hold #(
    .UUID     (UUID ^ 32'd1),
    .HOLD_MAX (HOLD_MAX)
  ) u_hold_counter (
    .clk   (clk),
    .rst_n (rst),
    .clr   (!own_d),
    .en    (own_q && own_d),
    .tc    (hold_tc)
  );

  // Next-state logic: arbitrate from IDLE/TURN, release voluntarily or by preemption from OWNn.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE, TURN: begin
        if (Req1 && (!Req2 || (last_q == LANE2))) begin
          state_d = OWN1;
        end else if (Req2) begin
          state_d = OWN2;
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        // A voluntary drop takes precedence, so Preempt stays low when both coincide.
        if (!Req1) begin
          state_d = TURN;
          last_d  = LANE1;
        end else if (hold_tc && Req2) begin
          state_d   = TURN;
          last_d    = LANE1;
          preempt_d = 1'b1;
        end
      end
      OWN2: begin
        if (!Req2) begin
          state_d = TURN;
          last_d  = LANE2;
        end else if (hold_tc && Req1) begin
          state_d   = TURN;
          last_d    = LANE2;
          preempt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last owner resets to lane 2 so lane 1 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= LANE2;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      preempt_q <= preempt_d;
    end
  end

  assign Grant1  = (state_q == OWN1);
  assign Grant2  = (state_q == OWN2);
  assign Output1 = Grant1 & Data1;
  assign Output2 = Grant2 & Data2;
  assign Preempt = preempt_q;

endmodule

// File: tb/tb_bus_lane_arbiter_x2.sv
// Directed bench for bus_lane_arbiter_x2: one instance without preemption
// (HOLD_MAX=0) and one with HOLD_MAX=4, both driven by the same stimulus.
module tb_bus_lane_arbiter_x2;

  logic clk = 1'b0;
  logic rst, Req1, Req2, Data1, Data2;
  logic g1_0, g2_0, o1_0, o2_0, p_0;
  logic g1_4, g2_4, o1_4, o2_4, p_4;
  logic [4:0] obs0, obs4;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  bus_lane_arbiter_x2 #(.UUID(0), .NAME("arb0"), .HOLD_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .Req1(Req1), .Req2(Req2), .Data1(Data1), .Data2(Data2),
    .Grant1(g1_0), .Grant2(g2_0), .Output1(o1_0), .Output2(o2_0), .Preempt(p_0)
  );

  bus_lane_arbiter_x2 #(.UUID(4), .NAME("arb4"), .HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .Req1(Req1), .Req2(Req2), .Data1(Data1), .Data2(Data2),
    .Grant1(g1_4), .Grant2(g2_4), .Output1(o1_4), .Output2(o2_4), .Preempt(p_4)
  );

  // Packed view {Grant1, Grant2, Output1, Output2, Preempt}.
  assign obs0 = {g1_0, g2_0, o1_0, o2_0, p_0};
  assign obs4 = {g1_4, g2_4, o1_4, o2_4, p_4};

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mutual exclusion of grants and lane drives, sampled every falling edge.
  always @(negedge clk) begin
    chk("excl_grant0", {7'd0, g1_0 & g2_0}, 8'd0);
    chk("excl_grant4", {7'd0, g1_4 & g2_4}, 8'd0);
    chk("excl_out4",   {7'd0, o1_4 & o2_4}, 8'd0);
  end

  initial begin
    rst = 1'b0; Req1 = 1'b1; Req2 = 1'b1; Data1 = 1'b1; Data2 = 1'b1;

    // Reset held with both requesting: everything low.
    step(); step();
    chk("rst_hold0", {3'd0, obs0}, 8'b000_00000);
    chk("rst_hold4", {3'd0, obs4}, 8'b000_00000);
    rst = 1'b1;
    step();
    chk("rst_first0", {3'd0, obs0}, 8'b000_10100);
    chk("rst_first4", {3'd0, obs4}, 8'b000_10100);

    // Handoff: Grant1 three cycles, one TURN, then Grant2.
    Req2 = 1'b0;
    step(); chk("hand_c2", {3'd0, obs4}, 8'b000_10100);
    step(); chk("hand_c3", {3'd0, obs4}, 8'b000_10100);
    Req1 = 1'b0; Req2 = 1'b1;
    step();
    chk("hand_turn0", {3'd0, obs0}, 8'b000_00000);
    chk("hand_turn4", {3'd0, obs4}, 8'b000_00000);
    step(); chk("hand_own2", {3'd0, obs4}, 8'b000_01010);
    Data2 = 1'b0; #1;
    chk("out2_follow", {3'd0, obs4}, 8'b000_01000);
    Data2 = 1'b1; Req2 = 1'b0;
    step(); chk("rel_turn", {3'd0, obs4}, 8'b000_00000);
    step(); chk("rel_idle", {3'd0, obs4}, 8'b000_00000);

    // Round-robin: each owner drops Req for one cycle after two granted cycles.
    Req1 = 1'b1; Req2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int ph;
      logic [4:0] e;
      ph = i % 6;
      step();
      e = (ph < 2) ? 5'b10100 : ((ph == 3 || ph == 4) ? 5'b01010 : 5'b00000);
      chk($sformatf("rr0_%0d", i), {3'd0, obs0}, {3'd0, e});
      chk($sformatf("rr4_%0d", i), {3'd0, obs4}, {3'd0, e});
      Req1 = (ph != 1);
      Req2 = (ph != 4);
    end

    // Preemption after four contended cycles on the HOLD_MAX=4 instance.
    rst = 1'b0; Req1 = 1'b1; Req2 = 1'b0;
    #1 rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("pre_own1_%0d", i), {3'd0, obs4}, 8'b000_10100);
      if (i == 2) Req2 = 1'b1;
    end
    step();
    chk("pre_turn4", {3'd0, obs4}, 8'b000_00001);
    chk("pre_none0", {3'd0, obs0}, 8'b000_10100);
    step();
    chk("pre_own2_4", {3'd0, obs4}, 8'b000_01010);
    chk("pre_keep0",  {3'd0, obs0}, 8'b000_10100);

    // Owner drops Req on the edge where preemption would fire: voluntary release.
    rst = 1'b0; Req1 = 1'b1; Req2 = 1'b0;
    #1 rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 2) Req2 = 1'b1;
    end
    Req1 = 1'b0;
    step(); chk("sim_turn", {3'd0, obs4}, 8'b000_00000);
    step(); chk("sim_own2", {3'd0, obs4}, 8'b000_01010);

    // No contention: grant held 20 cycles, counter pinned at HOLD_MAX.
    rst = 1'b0; Req1 = 1'b1; Req2 = 1'b0;
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("hold_%0d", i), {3'd0, obs4}, 8'b000_10100);
    end
    chk("hold_sat", {5'd0, dut4.u_hold_counter.count_q}, 8'd4);

    // Asynchronous reset while Grant2 drives a 1.
    Req1 = 1'b0; Req2 = 1'b1;
    step(); chk("ar_turn", {3'd0, obs4}, 8'b000_00000);
    step(); chk("ar_own2", {3'd0, obs4}, 8'b000_01010);
    #2 rst = 1'b0;
    #1;
    chk("ar_drop0", {3'd0, obs0}, 8'b000_00000);
    chk("ar_drop4", {3'd0, obs4}, 8'b000_00000);
    Req1 = 1'b1; Req2 = 1'b1;
    #1 rst = 1'b1;
    step();
    chk("ar_win0", {3'd0, obs0}, 8'b000_10100);
    chk("ar_win4", {3'd0, obs4}, 8'b000_10100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_lane_arbiter_x2.md
Name: bus_lane_arbiter_x2

Overview:
- Sequential arbiter that sits directly upstream of the 1-bit dual z-buffer stage.
- Owns two shared 1-bit bus lanes. Decides which of two requesters may drive, one at a time.
- Produces the lane-drive signals Output1/Output2 that feed the buffer's Input1/Input2. On those buffer inputs, high = drive 1 and low = released (Z downstream).
- Round-robin fairness, a guaranteed one-cycle turnaround gap between owners, and optional preemption after HOLD_MAX cycles.

Parameters:
- UUID, 0, instance identifier; XORed into child UUIDs.
- NAME, "", instance label; no functional effect.
- HOLD_MAX, 8, maximum consecutive grant cycles while the other side is requesting; 0 disables preemption.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Req1  input  1  requester 1 wants the bus.
- Req2  input  1  requester 2 wants the bus.
- Data1  input  1  value requester 1 drives while granted.
- Data2  input  1  value requester 2 drives while granted.
- Grant1  output  1  requester 1 owns the bus (registered).
- Grant2  output  1  requester 2 owns the bus (registered).
- Output1  output  1  Grant1 AND Data1; to z-buffer Input1.
- Output2  output  1  Grant2 AND Data2; to z-buffer Input2.
- Preempt  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; Grant1=Grant2=Preempt=0; Output1=Output2=0.
  - hold counter=0; last_owner=2, so requester 1 wins the first tie.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, OWN1, OWN2, TURN.
- Invariant: Grant1 & Grant2 is never 1. Output1 & Output2 is never 1.
- Arbitration (evaluated in IDLE and TURN):
  - Req1 only -> OWN1. Req2 only -> OWN2.
  - Both -> the requester that is not last_owner.
  - Neither -> IDLE.
  - Grant rises on the clock edge after the request is sampled (latency 1 cycle).
- OWNn:
  - Gnt_n=1. Output_n follows Data_n combinationally (no extra latency).
  - Hold counter increments each cycle and saturates at HOLD_MAX.
  - Req_n=0 at an edge -> TURN; Grant_n falls on that edge; last_owner=n.
  - Forced release:
    - Condition: HOLD_MAX>0, counter==HOLD_MAX-1, and the other Req=1.
    - Action -> TURN; Preempt=1 for exactly the TURN cycle; last_owner=n.
  - Other side not requesting -> the grant is held indefinitely and the counter saturates.
- TURN:
  - Exactly one cycle with both grants 0.
  - Counter cleared. Arbitration as above. Preempt cleared on exit.
- Minimum gap between two different owners: 1 full cycle with no grant.
- Simultaneous events:
  - Owner drops Req on the same edge as preemption would fire -> treated as voluntary release; Preempt stays 0.
- Data_n changing while not granted has no effect on outputs.
- Counter width: max(1, clog2(HOLD_MAX+1)).

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, OWN1=2'd1, OWN2=2'd2, TURN=2'd3) and lane-id constants (1, 2).
- One sub-module is natural: hold_counter (saturating counter with clear and terminal-count flag), parameterised by HOLD_MAX.
- Output gating stays inline.

Test Plan:
- Reset:
  - Stimulus: rst=0 with Req1=Req2=1, Data=1; release rst.
  - Required: all outputs 0 while rst=0. First edge after release -> Grant1=1, Output1=1, Grant2=0.
- Single requester handoff:
  - Stimulus: Req1 high for 3 cycles, then low; Req2 raised in the same cycle Req1 falls.
  - Required: Grant1 high for 3 cycles, then one TURN cycle with both grants 0, then Grant2=1.
- Round-robin:
  - Stimulus: HOLD_MAX=0; Req1=Req2=1 constantly, each requester dropping Req for one cycle after every 2 granted cycles.
  - Required: grants alternate 1,2,1,2 with a one-cycle gap each time; Preempt never 1.
- Preemption:
  - Stimulus: HOLD_MAX=4; Req1 held high, Req2 rises at cycle 2 of the grant.
  - Required: Grant1 high exactly 4 cycles, then Preempt=1 for one cycle with both grants 0, then Grant2=1.
- No preemption without contention:
  - Stimulus: HOLD_MAX=4; Req1 held 20 cycles, Req2=0.
  - Required: Grant1 stays 1 for all 20 cycles; Preempt=0; counter saturated at 4.
- Async reset mid-grant:
  - Stimulus: rst pulsed low between edges while Grant2=1, Data2=1.
  - Required: Output2 and Grant2 go 0 before the next edge. After release with both requesting, Grant1 wins.
